// File: rtl/xpb_table_builder.sv
// Builds the table (j*C) mod M, j = 0 .. 2^DIGIT_BITS-1, emitting one entry write every three cycles.
// Optional XPB_BUILD_RANGE_CHECK_EN rejects C >= M or M = 0 with an err flag instead of building.
module xpb_table_builder #(
    parameter int WORD_LEN   = 1024,
    parameter int DIGIT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_LEN-1:0]   base_in,
    input  logic [WORD_LEN-1:0]   modulus_in,
    output logic                  busy,
    output logic                  wr_en,
    output logic [DIGIT_BITS-1:0] wr_addr,
    output logic [WORD_LEN-1:0]   wr_data,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        ADD    = 3'd2,
        REDUCE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [DIGIT_BITS-1:0] LAST_J = {DIGIT_BITS{1'b1}};

    state_t                state_q, state_d;
    logic [DIGIT_BITS-1:0] j_q, j_d;
    logic [WORD_LEN-1:0]   acc_q, acc_d;
    logic [WORD_LEN:0]     sum_q, sum_d;
    logic [WORD_LEN-1:0]   c_q, c_d;
    logic [WORD_LEN-1:0]   m_q, m_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  wr_en_q, wr_en_d;
    logic [DIGIT_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_LEN-1:0]   wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  range_bad;
    logic                  sum_ge_m;

`ifdef XPB_BUILD_RANGE_CHECK_EN
    assign range_bad = (base_in >= modulus_in) || (modulus_in == '0);
`else
    assign range_bad = 1'b0;
`endif

    // Wrap-around of the low bits makes the truncated subtraction exact.
    assign sum_ge_m = (sum_q >= {1'b0, m_q});

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        c_d     = c_q;
        m_d     = m_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    c_d   = base_in;
                    m_d   = modulus_in;
                    j_d   = '0;
                    acc_d = '0;
                    err_d = range_bad;
                    state_d = range_bad ? DONE : WRITE;
                end
            end
            WRITE: state_d = (j_q == LAST_J) ? DONE : ADD;
            ADD: begin
                sum_d   = {1'b0, acc_q} + {1'b0, c_q};
                j_d     = j_q + 1'b1;
                state_d = REDUCE;
            end
            REDUCE: begin
                acc_d   = sum_ge_m ? (sum_q[WORD_LEN-1:0] - m_q) : sum_q[WORD_LEN-1:0];
                state_d = WRITE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they align with the state they describe.
    always_comb begin
        busy_d    = (state_d != IDLE);
        wr_en_d   = (state_d == WRITE);
        done_d    = (state_d == DONE);
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (state_d == WRITE) begin
            wr_addr_d = j_d;
            wr_data_d = acc_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            j_q       <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            c_q       <= '0;
            m_q       <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            acc_q     <= acc_d;
            sum_q     <= sum_d;
            c_q       <= c_d;
            m_q       <= m_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: doc/xpb_table_builder.md
XPB_TABLE_BUILDER -- requirements
Module: xpb_table_builder

Interface
REQ-001 SHALL have parameter: WORD_LEN, 1024, bit width of modulus, base and table entries.
REQ-002 SHALL have parameter: DIGIT_BITS, 5, table address width; table depth 2^DIGIT_BITS.
REQ-003 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  one-cycle request to build a table.
REQ-006 SHALL have port: base_in  input  WORD_LEN  constant C whose multiples fill the table; sampled with start.
REQ-007 SHALL have port: modulus_in  input  WORD_LEN  modulus M; sampled with start.
REQ-008 SHALL have port: busy  output  1  high from the cycle after accepted start through the done cycle.
REQ-009 SHALL have port: wr_en  output  1  table write strobe, one cycle per entry.
REQ-010 SHALL have port: wr_addr  output  DIGIT_BITS  entry index j.
REQ-011 SHALL have port: wr_data  output  WORD_LEN  entry value (j*C) mod M.
REQ-012 SHALL have port: done  output  1  one-cycle pulse after last write.
REQ-013 SHALL have port: err  output  1  range-check failure flag (see Configuration).

Function
REQ-014 SHALL generate, for j = 0 .. 2^DIGIT_BITS-1 in ascending order, entry j = (j*C) mod M, matching the digit-indexed lookup tables consumed by the modular squarer.
REQ-015 SHALL accept start only in IDLE; start while busy SHALL be ignored with no effect on the run in progress.
REQ-016 SHALL latch base_in and modulus_in on the accepting edge; later input changes SHALL not affect the run.
REQ-017 SHALL use states IDLE -> WRITE -> ADD -> REDUCE -> WRITE ... -> DONE -> IDLE.
REQ-018 WRITE: wr_en=1, wr_addr=j, wr_data=acc; if j = 2^DIGIT_BITS-1 go DONE, else go ADD.
REQ-019 ADD: sum <= acc + C computed at WORD_LEN+1 bits (no carry loss); j <= j+1.
REQ-020 REDUCE: acc <= (sum >= M) ? sum - M : sum, truncated to WORD_LEN bits.
REQ-021 Entry 0 SHALL be written as all zeros without an addition.
REQ-022 Timing, start sampled at edge 0: writes in cycles 1, 4, 7, ..., 1+3*(2^DIGIT_BITS-1); done in the following cycle; DIGIT_BITS=5 gives writes at 1..94, done at 95, IDLE at 96.
REQ-023 A new start SHALL be accepted in the cycle DONE returns to IDLE or later.
REQ-024 wr_en, done SHALL be low in every cycle not listed above; wr_addr/wr_data hold last values when wr_en low.
REQ-025 C = 0 SHALL produce all-zero entries; C = M-1 SHALL produce 0, M-1, M-2, ... (single subtraction suffices given C < M).

Reset
REQ-026 rst SHALL force state IDLE, j=0, acc=0, busy=0, wr_en=0, wr_addr=0, wr_data=0, done=0, err=0 immediately, regardless of clock.
REQ-027 rst asserted mid-run SHALL abort the run; no further writes; partially written table is not valid.
REQ-028 After rst deasserts, first start SHALL behave as from power-up.

Configuration
REQ-029 Macro XPB_BUILD_RANGE_CHECK_EN defined: on accepted start, if base_in >= modulus_in or modulus_in = 0, SHALL skip all writes, pulse done in cycle 1 with err=1; err holds until next accepted start or rst.
REQ-030 Macro undefined: no check; err tied to 0; out-of-range C gives unspecified table contents but identical timing.

Verification
REQ-031 WORD_LEN=8, DIGIT_BITS=2, C=0x07, M=0x0B, start -> writes (0,0x00),(1,0x07),(2,0x03),(3,0x0A) at cycles 1,4,7,10; done at 11.
REQ-032 WORD_LEN=8, DIGIT_BITS=2, C=0x0A, M=0x0B -> entries 0x00,0x0A,0x09,0x08.
REQ-033 WORD_LEN=8, C=0xFE, M=0xFF -> entry 2 = 0xFD (carry out of bit 7 retained).
REQ-034 Second start pulsed at cycle 5 with different C -> ignored; table and timing per first start.
REQ-035 rst asserted at cycle 6 -> wr_en never high again, busy=0 asynchronously; next start yields full correct table.
REQ-036 With XPB_BUILD_RANGE_CHECK_EN, C=0x0B, M=0x0B -> no wr_en, done and err high at cycle 1; without macro, same stimulus -> 4 writes, err=0.
